// File: rtl/i2c_slave_core_if.sv
// I2C target pin and core-side handshake bundle.
// The slave modport is the target controller; the master modport is the bus/core environment.
interface i2c_slave_core_if #(
    parameter int unsigned DATA_SIZE = 8
) ();
    logic                 i2c_scl_i;
    logic                 i2c_sda_i;
    logic                 i2c_sda_o;
    logic [DATA_SIZE-1:0] data_i;
    logic                 data_req_o;
    logic [DATA_SIZE-1:0] data_from_sda_o;
    logic                 data_valid_o;
    logic                 rw_o;
    logic                 busy_o;
    logic                 stop_o;

    modport slave (
        input  i2c_scl_i, i2c_sda_i, data_i,
        output i2c_sda_o, data_req_o, data_from_sda_o, data_valid_o, rw_o, busy_o, stop_o
    );

    modport master (
        output i2c_scl_i, i2c_sda_i, data_i,
        input  i2c_sda_o, data_req_o, data_from_sda_o, data_valid_o, rw_o, busy_o, stop_o
    );
endinterface

// File: rtl/i2c_slave_core.sv
// I2C target controller: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write-byte delivery and read-byte transmission. Open-drain SDA, no clock stretching.
module i2c_slave_core #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter logic [6:0]  SLAVE_ADDR = 7'h50
) (
    input  logic            i2c_core_clk_i,
    input  logic            reset_i,
    i2c_slave_core_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StRxData, StRxAck, StTxData, StTxAck, StWaitStop
    } state_e;

    logic       scl_s1_q, scl_s2_q, scl_h_q;
    logic       sda_s1_q, sda_s2_q, sda_h_q;
    logic [1:0] prime_q;
    logic       primed;
    logic       scl_rise_q, scl_fall_q, start_q, stop_det_q, sda_bit_q;

    state_e               state_q;
    logic [2:0]           cnt_q;
    logic [DATA_SIZE-1:0] shreg_q;
    logic                 first_q;   // next fall in TX loads a fresh byte
    logic                 ack_drv_q; // RX ACK already being driven
    logic                 sda_o_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 valid_q, req_q, stop_q, rw_q, busy_q;

    logic [DATA_SIZE-1:0] shifted;
    logic                 addr_hit;

    // Edge detection is gated until the history flops hold real pin samples, so a bus that
    // is mid-transfer when reset drops cannot produce a phantom START or STOP.
    assign primed   = (prime_q == 2'd3);
    assign shifted  = {shreg_q[DATA_SIZE-2:0], sda_bit_q};
    assign addr_hit = (shreg_q[DATA_SIZE-1:1] == SLAVE_ADDR) && (shreg_q[DATA_SIZE-1:1] != '0);

    // Synchronize pins and register one bus event per core cycle.
    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_h_q    <= 1'b1;
            prime_q    <= 2'd0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_det_q <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_s1_q   <= bus.i2c_scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_h_q    <= scl_s2_q;
            sda_s1_q   <= bus.i2c_sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_h_q    <= sda_s2_q;
            if (!primed) prime_q <= prime_q + 2'd1;
            scl_rise_q <= primed & scl_s2_q & ~scl_h_q;
            scl_fall_q <= primed & ~scl_s2_q & scl_h_q;
            start_q    <= primed & scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
            stop_det_q <= primed & scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
            sda_bit_q  <= sda_s2_q;
        end
    end

    // Protocol FSM with registered outputs; STOP and START override every state.
    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd7;
            shreg_q   <= '0;
            first_q   <= 1'b0;
            ack_drv_q <= 1'b0;
            sda_o_q   <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            stop_q    <= 1'b0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            stop_q  <= 1'b0;
            if (stop_det_q) begin
                state_q <= StIdle;
                sda_o_q <= 1'b1;
                busy_q  <= 1'b0;
                stop_q  <= 1'b1;
            end else if (start_q) begin
                state_q <= StAddr;
                cnt_q   <= 3'd7;
                sda_o_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StAddr: begin
                        if (scl_rise_q) begin
                            shreg_q <= shifted;
                            if (cnt_q == 3'd0) state_q <= StAddrAck;
                            else               cnt_q   <= cnt_q - 3'd1;
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall_q) begin
                            if (addr_hit) begin
                                sda_o_q <= 1'b0;
                                rw_q    <= shreg_q[0];
                                busy_q  <= 1'b1;
                                if (shreg_q[0]) begin
                                    state_q <= StTxData;
                                    first_q <= 1'b1;
                                end else begin
                                    state_q   <= StRxAck;
                                    ack_drv_q <= 1'b1;
                                end
                            end else begin
                                state_q <= StWaitStop;
                            end
                        end
                    end
                    StRxData: begin
                        if (scl_rise_q) begin
                            shreg_q <= shifted;
                            if (cnt_q == 3'd0) begin
                                data_q    <= shifted;
                                valid_q   <= 1'b1;
                                state_q   <= StRxAck;
                                ack_drv_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q - 3'd1;
                            end
                        end
                    end
                    StRxAck: begin
                        // First fall starts the ACK, second fall ends it.
                        if (scl_fall_q) begin
                            if (!ack_drv_q) begin
                                sda_o_q   <= 1'b0;
                                ack_drv_q <= 1'b1;
                            end else begin
                                sda_o_q <= 1'b1;
                                cnt_q   <= 3'd7;
                                state_q <= StRxData;
                            end
                        end
                    end
                    StTxData: begin
                        if (scl_fall_q) begin
                            if (first_q) begin
                                shreg_q <= bus.data_i;
                                sda_o_q <= bus.data_i[DATA_SIZE-1];
                                req_q   <= 1'b1;
                                first_q <= 1'b0;
                                cnt_q   <= 3'd7;
                            end else if (cnt_q == 3'd0) begin
                                sda_o_q <= 1'b1;
                                state_q <= StTxAck;
                            end else begin
                                shreg_q <= shreg_q << 1;
                                sda_o_q <= shreg_q[DATA_SIZE-2];
                                cnt_q   <= cnt_q - 3'd1;
                            end
                        end
                    end
                    StTxAck: begin
                        if (scl_rise_q) begin
                            if (!sda_bit_q) begin
                                state_q <= StTxData;
                                first_q <= 1'b1;
                            end else begin
                                state_q <= StWaitStop;
                            end
                        end
                    end
                    StWaitStop: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.i2c_sda_o       = sda_o_q;
    assign bus.data_req_o      = req_q;
    assign bus.data_from_sda_o = data_q;
    assign bus.data_valid_o    = valid_q;
    assign bus.rw_o            = rw_q;
    assign bus.busy_o          = busy_q;
    assign bus.stop_o          = stop_q;
endmodule
